// File: rtl/phy_link_ctrl.sv
`default_nettype none
// ============================================================================
// phy_link_ctrl: two-lane PHY link bring-up, lane activation and TX data gate
// Revision: 1.0
// ============================================================================
module phy_link_ctrl #(
  parameter int DATA_W     = 32,
  parameter int SYNC_COUNT = 4,
  parameter int ERR_LIMIT  = 3,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk_f,
  input  logic              reset_L,
  input  logic              enable,
  input  logic [1:0]        lane_en,
  input  logic              com_det0,
  input  logic              com_det1,
  input  logic              err_det0,
  input  logic              err_det1,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              active_lane0,
  output logic              active_lane1,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic              link_up,
  output logic              link_err,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRAIN  = 2'd1,
    ACTIVE = 2'd2,
    ERROR  = 2'd3
  } state_e;

  localparam int SW = $clog2(SYNC_COUNT + 1);
  localparam int EW = $clog2(ERR_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] SYNC_MAX = SW'(SYNC_COUNT);
  localparam logic [EW-1:0] ERR_MAX  = EW'(ERR_LIMIT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [1:0]          lock_q, lock_d;
  logic [1:0]          lane_en_q, lane_en_d;
  logic [SW-1:0]       sync_cnt_q [2];
  logic [SW-1:0]       sync_cnt_d [2];
  logic [EW-1:0]       err_cnt_q [2];
  logic [EW-1:0]       err_cnt_d [2];
  logic [TW-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic                active_lane0_q, active_lane0_d;
  logic                active_lane1_q, active_lane1_d;
  logic                valid_out_q, valid_out_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                link_up_q, link_up_d;
  logic                link_err_q, link_err_d;

  logic [1:0]          com_det, err_det;
  logic                all_locked, err_trip, pass_data;

  assign com_det = {com_det1, com_det0};
  assign err_det = {err_det1, err_det0};

  always_comb begin
    state_d    = state_q;
    lock_d     = lock_q;
    lane_en_d  = lane_en_q;
    tmo_cnt_d  = tmo_cnt_q;
    all_locked = 1'b0;
    err_trip   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sync_cnt_d[i] = sync_cnt_q[i];
      err_cnt_d[i]  = err_cnt_q[i];
    end

    case (state_q)
      IDLE: begin
        if (enable && lane_en != 2'b00) state_d = TRAIN;
      end
      TRAIN: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        for (int i = 0; i < 2; i++) begin
          if (lane_en[i]) begin
            // A locked lane keeps its lock even if COM drops out later in TRAIN.
            if (com_det[i]) begin
              if (sync_cnt_q[i] != SYNC_MAX) sync_cnt_d[i] = sync_cnt_q[i] + 1'b1;
            end else if (!lock_q[i]) begin
              sync_cnt_d[i] = '0;
            end
            if (sync_cnt_d[i] == SYNC_MAX) lock_d[i] = 1'b1;
          end else begin
            sync_cnt_d[i] = '0;
            lock_d[i]     = 1'b0;
          end
        end
        all_locked = (lane_en != 2'b00) && ((lock_d & lane_en) == lane_en);
        if (lane_en == 2'b00)           state_d = IDLE;
        else if (all_locked)            state_d = ACTIVE;
        else if (tmo_cnt_q == TMO_LAST) state_d = ERROR;
      end
      ACTIVE: begin
        for (int i = 0; i < 2; i++) begin
          if (lane_en[i]) begin
            if (err_det[i]) begin
              if (err_cnt_q[i] != ERR_MAX) err_cnt_d[i] = err_cnt_q[i] + 1'b1;
            end else begin
              err_cnt_d[i] = '0;
            end
            if (err_cnt_d[i] == ERR_MAX) err_trip = 1'b1;
          end else begin
            err_cnt_d[i] = '0;
          end
        end
        if (err_trip || lane_en != lane_en_q) state_d = TRAIN;
      end
      default: ;
    endcase

    if (!enable) state_d = IDLE;

    // lane_en is frozen on entry to ACTIVE so a later change can be detected.
    if (state_q != ACTIVE) lane_en_d = lane_en;

    if (state_d == IDLE || (state_d == TRAIN && state_q != TRAIN)) begin
      lock_d    = 2'b00;
      tmo_cnt_d = '0;
      for (int i = 0; i < 2; i++) begin
        sync_cnt_d[i] = '0;
        err_cnt_d[i]  = '0;
      end
    end

    pass_data      = (state_q == ACTIVE) && (state_d == ACTIVE);
    valid_out_d    = valid_in && pass_data;
    data_out_d     = (valid_in && pass_data) ? data_in : '0;
    active_lane0_d = (state_d == ACTIVE) && lane_en[0] && lock_d[0];
    active_lane1_d = (state_d == ACTIVE) && lane_en[1] && lock_d[1];
    link_up_d      = (state_d == ACTIVE);
    link_err_d     = (state_d == ERROR);
  end

  always_ff @(posedge clk_f) begin
    if (!reset_L) begin
      state_q        <= IDLE;
      lock_q         <= 2'b00;
      lane_en_q      <= 2'b00;
      tmo_cnt_q      <= '0;
      active_lane0_q <= 1'b0;
      active_lane1_q <= 1'b0;
      valid_out_q    <= 1'b0;
      data_out_q     <= '0;
      link_up_q      <= 1'b0;
      link_err_q     <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        sync_cnt_q[i] <= '0;
        err_cnt_q[i]  <= '0;
      end
    end else begin
      state_q        <= state_d;
      lock_q         <= lock_d;
      lane_en_q      <= lane_en_d;
      tmo_cnt_q      <= tmo_cnt_d;
      active_lane0_q <= active_lane0_d;
      active_lane1_q <= active_lane1_d;
      valid_out_q    <= valid_out_d;
      data_out_q     <= data_out_d;
      link_up_q      <= link_up_d;
      link_err_q     <= link_err_d;
      for (int i = 0; i < 2; i++) begin
        sync_cnt_q[i] <= sync_cnt_d[i];
        err_cnt_q[i]  <= err_cnt_d[i];
      end
    end
  end

  assign active_lane0 = active_lane0_q;
  assign active_lane1 = active_lane1_q;
  assign valid_out    = valid_out_q;
  assign data_out     = data_out_q;
  assign link_up      = link_up_q;
  assign link_err     = link_err_q;
  assign state        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_phy_link_ctrl.sv
`default_nettype none
// ============================================================================
// tb_phy_link_ctrl: scoreboard bench for phy_link_ctrl
// Revision: 1.0
// ============================================================================
module tb_phy_link_ctrl;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_TRAIN  = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [1:0] S_ERROR  = 2'd3;

  logic        clk_f = 1'b0;
  logic        reset_L, enable, com_det0, com_det1, err_det0, err_det1, valid_in;
  logic [1:0]  lane_en;
  logic [31:0] data_in;
  logic        active_lane0, active_lane1, valid_out, link_up, link_err;
  logic [31:0] data_out;
  logic [1:0]  state;

  int checks   = 0;
  int failures = 0;

  logic [38:0] exp_q [$];
  string       tag_q [$];

  phy_link_ctrl #(
    .DATA_W(32), .SYNC_COUNT(4), .ERR_LIMIT(3), .TIMEOUT(64)
  ) u_dut (
    .clk_f(clk_f), .reset_L(reset_L), .enable(enable), .lane_en(lane_en),
    .com_det0(com_det0), .com_det1(com_det1), .err_det0(err_det0), .err_det1(err_det1),
    .valid_in(valid_in), .data_in(data_in),
    .active_lane0(active_lane0), .active_lane1(active_lane1),
    .valid_out(valid_out), .data_out(data_out),
    .link_up(link_up), .link_err(link_err), .state(state)
  );

  always #5 clk_f = ~clk_f;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Packed as {state, link_up, link_err, active_lane0, active_lane1, valid_out, data_out}
  function automatic logic [38:0] ex(input logic [1:0] st, input logic a0, input logic a1,
                                     input logic vo, input logic [31:0] d);
    return {st, st == S_ACTIVE, st == S_ERROR, a0, a1, vo, d};
  endfunction

  task automatic cyc(input string tag, input logic [38:0] e);
    logic [38:0] got;
    logic [38:0] want;
    string       t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk_f);
    #1;
    got  = {state, link_up, link_err, active_lane0, active_lane1, valid_out, data_out};
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    check_eq(t, 64'(got), 64'(want));
  endtask

  initial begin
    logic [7:0] pat;

    // Reset with every input driven high
    reset_L = 1'b0; enable = 1'b1; lane_en = 2'b11; com_det0 = 1'b1; com_det1 = 1'b1;
    err_det0 = 1'b1; err_det1 = 1'b1; valid_in = 1'b1; data_in = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) cyc("reset", ex(S_IDLE, 0, 0, 0, 0));

    reset_L = 1'b1; enable = 1'b0; lane_en = 2'b00; com_det0 = 1'b0; com_det1 = 1'b0;
    err_det0 = 1'b0; err_det1 = 1'b0; valid_in = 1'b0; data_in = '0;
    cyc("idle_after_reset", ex(S_IDLE, 0, 0, 0, 0));
    enable = 1'b1;
    cyc("lane00_stays_idle", ex(S_IDLE, 0, 0, 0, 0));

    // Two-lane training
    lane_en = 2'b11; com_det0 = 1'b1; com_det1 = 1'b1;
    cyc("t2_enter_train", ex(S_TRAIN, 0, 0, 0, 0));
    for (int k = 1; k <= 4; k++)
      cyc("t2_training", (k == 4) ? ex(S_ACTIVE, 1, 1, 0, 0) : ex(S_TRAIN, 0, 0, 0, 0));
    valid_in = 1'b1; data_in = 32'hCAFE_0001; com_det0 = 1'b0; com_det1 = 1'b0;
    cyc("t2_data", ex(S_ACTIVE, 1, 1, 1, 32'hCAFE_0001));
    valid_in = 1'b0; data_in = '0;
    cyc("t2_no_valid", ex(S_ACTIVE, 1, 1, 0, 0));

    // Sustained errors on lane0 force retraining
    valid_in = 1'b1; data_in = 32'h1234_5678; err_det0 = 1'b1;
    cyc("t5_err1", ex(S_ACTIVE, 1, 1, 1, 32'h1234_5678));
    cyc("t5_err2", ex(S_ACTIVE, 1, 1, 1, 32'h1234_5678));
    cyc("t5_retrain", ex(S_TRAIN, 0, 0, 0, 0));
    err_det0 = 1'b0; valid_in = 1'b0; data_in = '0; com_det0 = 1'b1; com_det1 = 1'b1;
    for (int k = 1; k <= 4; k++)
      cyc("t5_relock", (k == 4) ? ex(S_ACTIVE, 1, 1, 0, 0) : ex(S_TRAIN, 0, 0, 0, 0));
    com_det0 = 1'b0; com_det1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      err_det0 = (k % 2 == 0);
      cyc("t5_sparse_err", ex(S_ACTIVE, 1, 1, 0, 0));
    end
    err_det0 = 1'b0;

    // lane_en change while ACTIVE retrains with only lane0
    lane_en = 2'b01; com_det0 = 1'b1; com_det1 = 1'b1;
    cyc("lane_change", ex(S_TRAIN, 0, 0, 0, 0));
    for (int k = 1; k <= 4; k++)
      cyc("lane0_relock", (k == 4) ? ex(S_ACTIVE, 1, 0, 0, 0) : ex(S_TRAIN, 0, 0, 0, 0));
    com_det0 = 1'b0; err_det1 = 1'b1;
    for (int k = 0; k < 4; k++) cyc("disabled_lane_err", ex(S_ACTIVE, 1, 0, 0, 0));
    err_det1 = 1'b0;

    // Broken COM sequence on lane0
    enable = 1'b0;
    cyc("t3_off", ex(S_IDLE, 0, 0, 0, 0));
    enable = 1'b1; com_det0 = 1'b0;
    cyc("t3_enter_train", ex(S_TRAIN, 0, 0, 0, 0));
    pat = 8'b1111_0111;
    for (int k = 0; k < 8; k++) begin
      com_det0 = pat[k]; com_det1 = 1'b1;
      cyc("t3_sync", (k == 7) ? ex(S_ACTIVE, 1, 0, 0, 0) : ex(S_TRAIN, 0, 0, 0, 0));
    end

    // Timeout with lane1 never seeing COM
    enable = 1'b0;
    cyc("t4_off", ex(S_IDLE, 0, 0, 0, 0));
    enable = 1'b1; lane_en = 2'b11; com_det0 = 1'b1; com_det1 = 1'b0;
    valid_in = 1'b1; data_in = 32'hDEAD_BEEF;
    cyc("t4_enter_train", ex(S_TRAIN, 0, 0, 0, 0));
    for (int k = 1; k <= 64; k++)
      cyc("t4_timeout", (k == 64) ? ex(S_ERROR, 0, 0, 0, 0) : ex(S_TRAIN, 0, 0, 0, 0));
    com_det1 = 1'b1;
    for (int k = 0; k < 5; k++) cyc("t4_error_hold", ex(S_ERROR, 0, 0, 0, 0));
    enable = 1'b0;
    cyc("t4_error_exit", ex(S_IDLE, 0, 0, 0, 0));
    enable = 1'b1; com_det1 = 1'b0;
    cyc("t4_retrain", ex(S_TRAIN, 0, 0, 0, 0));

    // Last lock lands on the timeout cycle
    for (int k = 1; k <= 64; k++) begin
      com_det1 = (k >= 61);
      cyc("t6_lock_vs_tmo", (k == 64) ? ex(S_ACTIVE, 1, 1, 0, 0) : ex(S_TRAIN, 0, 0, 0, 0));
    end
    cyc("t6_data_after_lock", ex(S_ACTIVE, 1, 1, 1, 32'hDEAD_BEEF));
    valid_in = 1'b0; data_in = '0;

    // enable drop on the locking cycle wins
    enable = 1'b0;
    cyc("t6_off", ex(S_IDLE, 0, 0, 0, 0));
    enable = 1'b1; com_det0 = 1'b1; com_det1 = 1'b1;
    cyc("t6_enter_train", ex(S_TRAIN, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) cyc("t6_train", ex(S_TRAIN, 0, 0, 0, 0));
    enable = 1'b0;
    cyc("t6_off_vs_lock", ex(S_IDLE, 0, 0, 0, 0));
    enable = 1'b1;
    cyc("t6_reenter", ex(S_TRAIN, 0, 0, 0, 0));
    for (int k = 1; k <= 4; k++)
      cyc("t6_fresh_count", (k == 4) ? ex(S_ACTIVE, 1, 1, 0, 0) : ex(S_TRAIN, 0, 0, 0, 0));

    // Reset in the middle of ACTIVE traffic
    valid_in = 1'b1; data_in = 32'h0000_0001; reset_L = 1'b0;
    cyc("reset_midop", ex(S_IDLE, 0, 0, 0, 0));
    reset_L = 1'b1; enable = 1'b0;
    cyc("idle_after_midop", ex(S_IDLE, 0, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
